uart_tx_fifo_send: RTL and testbench
====================================

# uart_tx_fifo_send

Byte-stream UART transmitter sitting directly downstream of the frame packer. Accepts the packer's back-to-back `wr_en`/`wr_data` burst (one byte per clock, up to 32 bytes: header, payload, CRC, tail) into an internal FIFO. Drains the FIFO onto `txd` as 8N1 serial frames at a fixed baud divisor. Decouples the single-cycle-per-byte packer from the slow serial line, so a full 32-byte frame is absorbed without loss.

## Interface
- `BAUD_DIV`, 434: clocks per serial bit (50 MHz / 115200); legal range 2..65535.
- `FIFO_DEPTH`, 32: FIFO entries; power of two, minimum 2.
- `clk` input 1: system clock, all logic on rising edge.
- `reset` input 1: synchronous, active-high; clock `clk`.
- `wr_en` input 1: write strobe; the byte is captured on every edge where it is high.
- `wr_data` input 8: byte to transmit.
- `txd` output 1: serial line, idle high.
- `busy` output 1: high whenever the FSM is not IDLE.
- `fifo_empty` output 1: FIFO holds 0 bytes.
- `fifo_full` output 1: FIFO holds `FIFO_DEPTH` bytes.
- `fifo_count` output $clog2(FIFO_DEPTH)+1: current occupancy.
- `overflow` output 1: one-cycle pulse when a write is dropped.

## Operation
- Reset values: `txd`=1, `busy`=0, `fifo_empty`=1, `fifo_full`=0, `fifo_count`=0, `overflow`=0. Pointers and count are cleared; FSM is IDLE; baud and bit counters are 0. FIFO storage is not cleared.
- **FIFO write:** accepted when `wr_en` is high and either (count < `FIFO_DEPTH`) or a pop occurs on the same edge. Otherwise the byte is dropped, `overflow`=1 for that cycle, and the count is unchanged.
- **Simultaneous write and pop:** the count is unchanged and both pointers advance.
- **Pointer wrap:** pointers wrap modulo `FIFO_DEPTH` and carry no extra state.
- **Pop:** only issued by the FSM, only when count > 0. A byte written on edge k is not visible to the FSM until after edge k.
- **FSM states:** IDLE, START, DATA, STOP, plus PARITY when configured.
  - IDLE: if `fifo_empty`=0, pop the head byte into the shift register, set `txd`=0, go to START.
  - START: hold `txd`=0 for `BAUD_DIV` cycles, then go to DATA with `txd`=bit0.
  - DATA: 8 bits, LSB first, each held `BAUD_DIV` cycles. The bit counter runs 0..7; after bit 7 go to STOP (or PARITY).
  - STOP: `txd`=1 for `BAUD_DIV` cycles. On the final STOP cycle, if the FIFO is non-empty, pop and go straight to START (no idle gap). Otherwise go to IDLE.
- **Baud counter:** counts 0..`BAUD_DIV`-1 and wraps at each bit boundary.
- `txd` is driven from a register and is glitch-free.
- **Reset mid-frame:** `txd` returns to 1 on the reset edge. The in-flight byte and all queued bytes are discarded.

## Timing
- Latency: `wr_en` sampled on edge k into an empty FIFO with FSM IDLE → FSM pops on edge k+1 and `txd` is low from edge k+1.
- Each serial frame lasts exactly 10×`BAUD_DIV` cycles (11× with parity).
- Back-to-back frames follow with zero idle cycles between them.
- `fifo_count`, `fifo_full`, `fifo_empty` update on the same edge as the write or pop.
- `overflow` is registered: high for the cycle after the dropped write edge.
- `busy` rises on the pop edge and falls on the edge that enters IDLE.

## Configuration
- `UART_TX_PARITY_EN` defined: a PARITY state is inserted after DATA. It drives even parity (XOR of the 8 data bits) for `BAUD_DIV` cycles, giving 11-bit frames.
- `UART_TX_PARITY_EN` undefined: there is no PARITY state, frames are 8N1 (10 bits), and no parity logic is synthesised.

## Test plan
1. `BAUD_DIV`=4; single write 0xA5 to idle block → `txd`=0,1,0,1,0,0,1,0,1,1, each level held 4 cycles, starting one edge after the write; `busy` high for 40 cycles.
2. `BAUD_DIV`=4; 32-byte burst 55 BB 00 1A, payload 0x00..0x19, CRC 0x3C, F0 on 32 consecutive cycles → `fifo_full` never asserts while popping, no `overflow`, all 32 bytes decoded in order, last stop bit ends 1280 cycles after the first start.
3. `FIFO_DEPTH`=4, `BAUD_DIV`=4; 6 consecutive writes 0x01..0x06 → the first pops immediately; 0x01..0x05 are transmitted; 0x06 is dropped with a single `overflow` pulse; `fifo_count` peaks at 4.
4. FIFO full and FSM on its final STOP cycle, `wr_en`=1 with 0x77 → write accepted, `fifo_count` stays at `FIFO_DEPTH`, no `overflow`, and 0x77 is transmitted last.
5. `reset` asserted mid-DATA of 0xFF with 3 bytes queued → `txd`=1 and `fifo_empty`=1 after the reset edge; no further frames until a new write.
6. `UART_TX_PARITY_EN` defined, byte 0x07 → parity bit 1, frame length 11×`BAUD_DIV`; byte 0xA5 → parity bit 0.

Source files
------------

// File: rtl/uart_tx_fifo_send.sv
// Byte-stream 8N1 UART transmitter with an internal FIFO that absorbs full packer bursts.
// Optional macro UART_TX_PARITY_EN inserts an even-parity bit (11-bit frames).
module uart_tx_fifo_send #(
    parameter int unsigned BAUD_DIV   = 434,
    parameter int unsigned FIFO_DEPTH = 32
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          wr_en,
    input  logic [7:0]                    wr_data,
    output logic                          txd,
    output logic                          busy,
    output logic                          fifo_empty,
    output logic                          fifo_full,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow
);

    localparam int unsigned    AW        = $clog2(FIFO_DEPTH);
    localparam int unsigned    CW        = AW + 1;
    localparam logic [CW-1:0]  DEPTH_C   = CW'(FIFO_DEPTH);
    localparam logic [15:0]    BAUD_LAST = 16'(BAUD_DIV - 1);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_e;
`else
    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_e;
`endif

    state_e          state_q, state_d;
    logic [7:0]      mem_q [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            overflow_q, overflow_d;
    logic [15:0]     baud_q, baud_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      data_q, data_d;
    logic            txd_q, txd_d;
    logic            push, pop, bit_end;

    assign bit_end    = (baud_q == BAUD_LAST);
    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == DEPTH_C);
    assign fifo_count = count_q;
    assign overflow   = overflow_q;
    assign txd        = txd_q;
    assign busy       = (state_q != S_IDLE);

    // A full FIFO still accepts a byte when the FSM frees a slot on the same edge.
    assign push = wr_en && (!fifo_full || pop);

    always_comb begin
        wr_ptr_d   = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d   = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        overflow_d = wr_en && !push;
        count_d    = count_q;
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CW'(1);
        end
    end

    // NOTE: storage carries no reset; only pointers and count define which entries are valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    // NOTE: every sequential assignment is non-blocking so all registers update from pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            baud_q     <= '0;
            bit_q      <= '0;
            data_q     <= '0;
            txd_q      <= 1'b1;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            baud_q     <= baud_d;
            bit_q      <= bit_d;
            data_q     <= data_d;
            txd_q      <= txd_d;
        end
    end

    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:   if (!fifo_empty) state_d = S_START;
            S_START:  if (bit_end) state_d = S_DATA;
`ifdef UART_TX_PARITY_EN
            S_DATA:   if (bit_end && bit_q == 3'd7) state_d = S_PARITY;
            S_PARITY: if (bit_end) state_d = S_STOP;
`else
            S_DATA:   if (bit_end && bit_q == 3'd7) state_d = S_STOP;
`endif
            S_STOP:   if (bit_end) state_d = fifo_empty ? S_IDLE : S_START;
            default:  state_d = S_IDLE;
        endcase
    end

    // txd_d is the level for the next bit period, so the line changes exactly on bit boundaries.
    always_comb begin
        pop    = 1'b0;
        txd_d  = txd_q;
        bit_d  = bit_q;
        data_d = data_q;
        baud_d = bit_end ? '0 : baud_q + 16'd1;
        unique case (state_q)
            S_IDLE: begin
                baud_d = '0;
                bit_d  = '0;
                txd_d  = 1'b1;
                if (!fifo_empty) begin
                    pop    = 1'b1;
                    data_d = mem_q[rd_ptr_q];
                    txd_d  = 1'b0;
                end
            end
            S_START: begin
                if (bit_end) txd_d = data_q[0];
            end
            S_DATA: begin
                if (bit_end) begin
                    if (bit_q == 3'd7) begin
                        bit_d = '0;
`ifdef UART_TX_PARITY_EN
                        txd_d = ^data_q;
`else
                        txd_d = 1'b1;
`endif
                    end else begin
                        bit_d = bit_q + 3'd1;
                        txd_d = data_q[bit_q + 3'd1];
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (bit_end) txd_d = 1'b1;
            end
`endif
            S_STOP: begin
                if (bit_end) begin
                    txd_d = 1'b1;
                    if (!fifo_empty) begin
                        pop    = 1'b1;
                        data_d = mem_q[rd_ptr_q];
                        txd_d  = 1'b0;
                    end
                end
            end
            default: begin
                txd_d = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_tx_fifo_send.sv
// Self-checking bench for uart_tx_fifo_send: a 32-deep and a 4-deep instance at BAUD_DIV=4,
// with a serial decoder popping expected bytes from a scoreboard queue.
module tb_uart_tx_fifo_send;

    localparam int B = 4;
`ifdef UART_TX_PARITY_EN
    localparam int FB = 11;
`else
    localparam int FB = 10;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;

    logic       wr_en_a = 1'b0;
    logic [7:0] wr_data_a = 8'h00;
    logic       txd_a, busy_a, empty_a, full_a, ovf_a;
    logic [5:0] count_a;

    logic       wr_en_b = 1'b0;
    logic [7:0] wr_data_b = 8'h00;
    logic       txd_b, busy_b, empty_b, full_b, ovf_b;
    logic [2:0] count_b;

    logic       sel_b = 1'b0;
    logic       txd_mon;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    int ovf_cnt_a, ovf_cnt_b, full_seen_a, peak_b;

    logic [7:0] exp_q[$];

    uart_tx_fifo_send #(.BAUD_DIV(B), .FIFO_DEPTH(32)) dut_a (
        .clk(clk), .reset(reset), .wr_en(wr_en_a), .wr_data(wr_data_a),
        .txd(txd_a), .busy(busy_a), .fifo_empty(empty_a), .fifo_full(full_a),
        .fifo_count(count_a), .overflow(ovf_a)
    );

    uart_tx_fifo_send #(.BAUD_DIV(B), .FIFO_DEPTH(4)) dut_b (
        .clk(clk), .reset(reset), .wr_en(wr_en_b), .wr_data(wr_data_b),
        .txd(txd_b), .busy(busy_b), .fifo_empty(empty_b), .fifo_full(full_b),
        .fifo_count(count_b), .overflow(ovf_b)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign txd_mon = sel_b ? txd_b : txd_a;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (ovf_a) ovf_cnt_a++;
        if (ovf_b) ovf_cnt_b++;
        if (full_a) full_seen_a++;
        if (int'(count_b) > peak_b) peak_b = int'(count_b);
    endtask

    task automatic wait_drain(input logic use_b, input int budget, input string name);
        int n = 0;
        while (((use_b ? busy_b : busy_a) || !(use_b ? empty_b : empty_a) || exp_q.size() != 0)
               && n < budget) begin
            step();
            n++;
        end
        check(name, n < budget, 1);
    endtask

    // Serial decoder: samples mid-bit on the falling edge, counting from the first low cycle.
    int         m_cnt = 0;
    logic       m_act = 1'b0;
    logic [10:0] m_bits;
    logic [7:0] m_byte;

    always @(negedge clk) begin
        if (reset) begin
            m_act = 1'b0;
        end else begin
            if (!m_act && txd_mon === 1'b0) begin
                m_act = 1'b1;
                m_cnt = 0;
            end
            if (m_act) begin
                if (m_cnt % B == B / 2) m_bits[m_cnt / B] = txd_mon;
                if (m_cnt == (FB - 1) * B + B / 2) begin
                    m_act  = 1'b0;
                    m_byte = m_bits[8:1];
                    check("start_bit", m_bits[0], 0);
                    check("stop_bit", m_bits[FB-1], 1);
`ifdef UART_TX_PARITY_EN
                    check("parity_bit", m_bits[9], ^m_byte);
`endif
                    check("frame_expected", exp_q.size() != 0, 1);
                    if (exp_q.size() != 0) check("rx_byte", m_byte, exp_q.pop_front());
                end else begin
                    m_cnt++;
                end
            end
        end
    end

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic       wr_en;
        logic [7:0] data;
        logic       txd;
        logic       busy;
        logic       empty;
        logic [5:0] count;
    } vec_t;

    vec_t       vt[FB*B+2];
    logic [10:0] fr;
    logic [7:0] burst[32];

    initial begin
        // Single-frame vectors for 0xA5: write, then one record per cycle of the frame.
        fr = '1;
        fr[0] = 1'b0;
        fr[8:1] = 8'hA5;
`ifdef UART_TX_PARITY_EN
        fr[9] = 1'b0;
`endif
        vt[0] = '{1'b1, 8'hA5, 1'b1, 1'b0, 1'b0, 6'd1};
        for (int i = 1; i <= FB * B; i++) vt[i] = '{1'b0, 8'h00, fr[(i-1)/B], 1'b1, 1'b1, 6'd0};
        vt[FB*B+1] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 6'd0};

        burst[0] = 8'h55; burst[1] = 8'hBB; burst[2] = 8'h00; burst[3] = 8'h1A;
        for (int i = 0; i < 26; i++) burst[4+i] = 8'(i);
        burst[30] = 8'h3C; burst[31] = 8'hF0;

        // Reset state
        step(); step();
        reset = 1'b0;
        check("rst_txd_a", txd_a, 1);     check("rst_busy_a", busy_a, 0);
        check("rst_empty_a", empty_a, 1); check("rst_full_a", full_a, 0);
        check("rst_count_a", count_a, 0); check("rst_ovf_a", ovf_a, 0);
        check("rst_txd_b", txd_b, 1);     check("rst_count_b", count_b, 0);
        step();

        // Single byte, cycle-exact waveform
        for (int i = 0; i < FB * B + 2; i++) begin
            wr_en_a = vt[i].wr_en;
            wr_data_a = vt[i].data;
            if (vt[i].wr_en) exp_q.push_back(vt[i].data);
            step();
            wr_en_a = 1'b0;
            check($sformatf("t1_txd[%0d]", i), txd_a, vt[i].txd);
            check($sformatf("t1_busy[%0d]", i), busy_a, vt[i].busy);
            check($sformatf("t1_empty[%0d]", i), empty_a, vt[i].empty);
            check($sformatf("t1_count[%0d]", i), count_a, vt[i].count);
        end
        wait_drain(1'b0, 100, "t1_drain");

        // 32-byte back-to-back burst into the 32-deep instance
        begin
            int t0 = 0;
            ovf_cnt_a = 0;
            full_seen_a = 0;
            for (int i = 0; i < 32; i++) begin
                wr_en_a = 1'b1;
                wr_data_a = burst[i];
                exp_q.push_back(burst[i]);
                step();
                if (i == 0) t0 = cyc;
            end
            wr_en_a = 1'b0;
            begin
                int n = 0;
                while (busy_a && n < 32 * FB * B + 50) begin
                    step();
                    n++;
                end
            end
            check("t2_busy_done", busy_a, 0);
            check("t2_duration", cyc - (t0 + 1), 32 * FB * B);
            check("t2_no_full", full_seen_a, 0);
            check("t2_no_overflow", ovf_cnt_a, 0);
            step(); step();
            check("t2_all_rx", exp_q.size(), 0);
        end

        // Overflow on a 4-deep FIFO: 6 writes, 0x06 dropped
        sel_b = 1'b1;
        step();
        ovf_cnt_b = 0;
        peak_b = 0;
        for (int i = 0; i < 6; i++) begin
            wr_en_b = 1'b1;
            wr_data_b = 8'(i + 1);
            if (i < 5) exp_q.push_back(8'(i + 1));
            step();
            if (i == 4) check("t3_full_at_peak", full_b, 1);
        end
        wr_en_b = 1'b0;
        check("t3_ovf_after_drop", ovf_b, 1);
        step();
        check("t3_ovf_one_cycle", ovf_b, 0);
        wait_drain(1'b1, 6 * FB * B + 50, "t3_drain");
        check("t3_ovf_pulses", ovf_cnt_b, 1);
        check("t3_peak_count", peak_b, 4);

        // Full FIFO, write lands on the final STOP edge of the frame in flight
        step();
        ovf_cnt_b = 0;
        for (int i = 0; i < 5; i++) begin
            wr_en_b = 1'b1;
            wr_data_b = 8'(8'h10 + i);
            exp_q.push_back(8'(8'h10 + i));
            step();
        end
        wr_en_b = 1'b0;
        check("t4_full_before", full_b, 1);
        check("t4_count_before", count_b, 4);
        for (int i = 0; i < FB * B - 4; i++) step();
        wr_en_b = 1'b1;
        wr_data_b = 8'h77;
        exp_q.push_back(8'h77);
        step();
        wr_en_b = 1'b0;
        check("t4_count_after", count_b, 4);
        check("t4_no_overflow", ovf_b, 0);
        check("t4_busy_no_gap", busy_b, 1);
        wait_drain(1'b1, 7 * FB * B + 50, "t4_drain");
        check("t4_ovf_total", ovf_cnt_b, 0);

        // Reset mid-DATA of 0xFF with three bytes queued
        sel_b = 1'b0;
        step();
        for (int i = 0; i < 4; i++) begin
            wr_en_a = 1'b1;
            wr_data_a = (i == 0) ? 8'hFF : 8'(i);
            step();
        end
        wr_en_a = 1'b0;
        for (int i = 0; i < 12; i++) step();
        check("t5_count_before", count_a, 3);
        check("t5_busy_before", busy_a, 1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("t5_txd", txd_a, 1);
        check("t5_empty", empty_a, 1);
        check("t5_busy", busy_a, 0);
        check("t5_count", count_a, 0);
        begin
            int lows = 0;
            int busys = 0;
            for (int i = 0; i < 100; i++) begin
                step();
                if (!txd_a) lows++;
                if (busy_a) busys++;
            end
            check("t5_line_quiet", lows, 0);
            check("t5_stays_idle", busys, 0);
        end

        // Fresh byte after reset (odd parity content)
        wr_en_a = 1'b1;
        wr_data_a = 8'h07;
        exp_q.push_back(8'h07);
        step();
        wr_en_a = 1'b0;
        wait_drain(1'b0, FB * B + 50, "t6_drain");
        check("t6_queue_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
